// File: rtl/card_color_shuffler_pkg.sv
// ---------------------------------------------------------------------------
// card_color_shuffler_pkg : shared card constants, palette, LFSR taps, states
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package card_color_shuffler_pkg;

  localparam int CARD_ADDRESS_SIZE = 5;
  localparam int CARD_COLOR_SIZE   = 12;
  localparam int CARD_MAX_NUM_SIZE = 6;
  localparam int CARD_MAX_CARDS    = 20;

  // Galois mask for x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam logic [11:0] PAIR_COLOR_0 = 12'hF00;
  localparam logic [11:0] PAIR_COLOR_1 = 12'h0F0;
  localparam logic [11:0] PAIR_COLOR_2 = 12'h00F;
  localparam logic [11:0] PAIR_COLOR_3 = 12'hFF0;
  localparam logic [11:0] PAIR_COLOR_4 = 12'hF0F;
  localparam logic [11:0] PAIR_COLOR_5 = 12'h0FF;
  localparam logic [11:0] PAIR_COLOR_6 = 12'hF80;
  localparam logic [11:0] PAIR_COLOR_7 = 12'h8F0;
  localparam logic [11:0] PAIR_COLOR_8 = 12'h08F;
  localparam logic [11:0] PAIR_COLOR_9 = 12'hFFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FILL    = 2'd1,
    ST_SHUFFLE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // 12'h000 means "no card", so out-of-palette pairs fall back to it
  function automatic logic [11:0] pair_color(input int idx);
    logic [11:0] c;
    case (idx)
      0:       c = PAIR_COLOR_0;
      1:       c = PAIR_COLOR_1;
      2:       c = PAIR_COLOR_2;
      3:       c = PAIR_COLOR_3;
      4:       c = PAIR_COLOR_4;
      5:       c = PAIR_COLOR_5;
      6:       c = PAIR_COLOR_6;
      7:       c = PAIR_COLOR_7;
      8:       c = PAIR_COLOR_8;
      9:       c = PAIR_COLOR_9;
      default: c = 12'h000;
    endcase
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/card_color_shuffler_lfsr16.sv
// ---------------------------------------------------------------------------
// lfsr16 : free-running 16-bit Galois LFSR, loads SEED on reset
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lfsr16
  import card_color_shuffler_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] state
);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SEED;
    end else begin
      state <= {1'b0, state[15:1]} ^ (state[0] ? LFSR_TAPS : 16'h0000);
    end
  end

endmodule

`default_nettype wire

// File: rtl/card_color_shuffler.sv
// ---------------------------------------------------------------------------
// card_color_shuffler : fills the card colour table with pairs, Fisher-Yates
// shuffles it with an LFSR, raises compute_done, serves a registered read port
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module card_color_shuffler
  import card_color_shuffler_pkg::*;
#(
  parameter int          MAX_CARDS = CARD_MAX_CARDS,
  parameter int          ADDR_W    = CARD_ADDRESS_SIZE,
  parameter int          NUM_W     = CARD_MAX_NUM_SIZE,
  parameter int          COLOR_W   = CARD_COLOR_SIZE,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          RETRY_MAX = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               compute_colors_en,
  input  logic [NUM_W-1:0]   num_of_cards,
  output logic               compute_done,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [COLOR_W-1:0] rd_color
);

  localparam int RETRY_W = $clog2(RETRY_MAX + 1);

  state_t               state;
  state_t               state_next;
  logic [15:0]          lfsr;
  logic [NUM_W-1:0]     n_eff;
  logic [NUM_W-1:0]     n_reg;
  logic [ADDR_W-1:0]    idx_i;
  logic [ADDR_W-1:0]    cand_j;
  logic [ADDR_W-1:0]    swap_j;
  logic [RETRY_W-1:0]   retry;
  logic                 take_swap;
  logic [COLOR_W-1:0]   tbl [MAX_CARDS];
  logic                 unused_lfsr_hi;

  lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .state (lfsr)
  );

  assign unused_lfsr_hi = ^lfsr[15:ADDR_W];

  // Deck size is forced even, then clamped to the table size
  always_comb begin
    n_eff = num_of_cards & ~NUM_W'(1);
    if (n_eff > NUM_W'(MAX_CARDS)) begin
      n_eff = NUM_W'(MAX_CARDS);
    end
  end

  assign cand_j    = lfsr[ADDR_W-1:0];
  assign take_swap = (cand_j <= idx_i) || (retry == RETRY_W'(RETRY_MAX));
  assign swap_j    = (cand_j <= idx_i) ? cand_j : idx_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (compute_colors_en) state_next = ST_FILL;
      end
      ST_FILL: begin
        if (!compute_colors_en)          state_next = ST_IDLE;
        else if (n_reg < NUM_W'(2))      state_next = ST_DONE;
        else                             state_next = ST_SHUFFLE;
      end
      ST_SHUFFLE: begin
        if (!compute_colors_en)                      state_next = ST_IDLE;
        else if (take_swap && idx_i == ADDR_W'(1))   state_next = ST_DONE;
      end
      ST_DONE: begin
        if (!compute_colors_en) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Registered from the next state so done rises on the same edge DONE is entered
  always_ff @(posedge clk) begin
    if (rst) begin
      compute_done <= 1'b0;
    end else begin
      compute_done <= (state_next == ST_DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      n_reg <= '0;
      idx_i <= '0;
      retry <= '0;
      for (int k = 0; k < MAX_CARDS; k++) begin
        tbl[k] <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (compute_colors_en) n_reg <= n_eff;
        end
        ST_FILL: begin
          for (int k = 0; k < MAX_CARDS; k++) begin
            tbl[k] <= (k < int'(n_reg)) ? COLOR_W'(pair_color(k >> 1)) : '0;
          end
          idx_i <= ADDR_W'(n_reg - NUM_W'(1));
          retry <= '0;
        end
        ST_SHUFFLE: begin
          if (take_swap) begin
            tbl[idx_i]  <= tbl[swap_j];
            tbl[swap_j] <= tbl[idx_i];
            idx_i       <= idx_i - ADDR_W'(1);
            retry       <= '0;
          end else begin
            retry <= retry + RETRY_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Nonblocking table writes mean a same-cycle swap is seen after this read
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_color <= '0;
    end else if (int'(rd_addr) < MAX_CARDS) begin
      rd_color <= tbl[rd_addr];
    end else begin
      rd_color <= '0;
    end
  end

endmodule

`default_nettype wire
